// File: rtl/worker_dispatcher_pkg.sv
// worker_dispatcher_pkg
//   Shared widths, result field layout and helpers for the worker dispatcher
//   and anything that builds or decodes worker results (including the bench).
//   Result format: {dest_option[2:0], dest_addr[15:0], color[15:0], data[31:0]}.
package worker_dispatcher_pkg;

   localparam int PACKET_WIDTH        = 64;
   localparam int WORKER_RESULT_WIDTH = 67;
   localparam int NUM_WORKERS         = 4;
   localparam int PTR_WIDTH           = $clog2(NUM_WORKERS);

   // Result field offsets (LSB of each field)
   localparam int RES_DATA_LSB   = 0;
   localparam int RES_COLOR_LSB  = 32;
   localparam int RES_ADDR_LSB   = 48;
   localparam int RES_OPT_LSB    = 64;

   typedef logic [PACKET_WIDTH-1:0]        packet_t;
   typedef logic [WORKER_RESULT_WIDTH-1:0] worker_result_t;

   typedef struct packed {
      logic [2:0]  dest_option;
      logic [15:0] dest_addr;
      logic [15:0] color;
      logic [31:0] data;
   } worker_result_s;

   function automatic worker_result_t make_worker_result(
      input logic [2:0]  dest_option,
      input logic [15:0] dest_addr,
      input logic [15:0] color,
      input logic [31:0] data);
      worker_result_s r;
      r.dest_option = dest_option;
      r.dest_addr   = dest_addr;
      r.color       = color;
      r.data        = data;
      return worker_result_t'(r);
   endfunction

   // Round-robin pointer advance: one past the granted index, wrapping at NUM_WORKERS
   function automatic logic [PTR_WIDTH-1:0] rr_next(input logic [PTR_WIDTH-1:0] idx);
      return (idx == PTR_WIDTH'(NUM_WORKERS-1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/worker_dispatcher_if.sv
// worker_dispatcher_if
//   Bundles the packet-in, per-worker packet-out, per-worker result-in and
//   merged result-out handshakes plus BUSY.
//   slave : dispatcher view (drives READY upstream, VALID/DATA downstream)
//   master: environment view (source, workers and writeback side)
interface worker_dispatcher_if;
   import worker_dispatcher_pkg::*;

   logic                                             RECEIVE_PC_VALID;
   logic                                             RECEIVE_PC_READY;
   packet_t                                          RECEIVE_PC_DATA;
   logic [NUM_WORKERS-1:0]                           SEND_W_VALID;
   logic [NUM_WORKERS-1:0]                           SEND_W_READY;
   packet_t                                          SEND_W_DATA;
   logic [NUM_WORKERS-1:0]                           RECEIVE_WR_VALID;
   logic [NUM_WORKERS-1:0]                           RECEIVE_WR_READY;
   logic [NUM_WORKERS-1:0][WORKER_RESULT_WIDTH-1:0]  RECEIVE_WR_DATA;
   logic                                             SEND_WR_VALID;
   logic                                             SEND_WR_READY;
   worker_result_t                                   SEND_WR_DATA;
   logic                                             BUSY;

   modport slave (
      input  RECEIVE_PC_VALID, RECEIVE_PC_DATA, SEND_W_READY,
             RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY,
      output RECEIVE_PC_READY, SEND_W_VALID, SEND_W_DATA,
             RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA, BUSY
   );

   modport master (
      output RECEIVE_PC_VALID, RECEIVE_PC_DATA, SEND_W_READY,
             RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY,
      input  RECEIVE_PC_READY, SEND_W_VALID, SEND_W_DATA,
             RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA, BUSY
   );

endinterface

// File: rtl/worker_dispatcher_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: first requester at or after ptr (mod N).
//   Ports: req[N] in, ptr in; grant[N] one-hot out, grant_idx out, any out.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         any
);

   logic [W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/worker_dispatcher.sv
// worker_dispatcher
//   Takes one packet stream and hands each packet to one ready worker
//   (round robin), and merges worker results into one stream (round robin).
//   One registered slot per side gives one packet in and one result out per cycle.
//   Ports: CLK, RST (sync, active high); io (worker_dispatcher_if.slave) carries
//   all handshakes, data and BUSY.
module worker_dispatcher
   import worker_dispatcher_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   worker_dispatcher_if.slave  io
);

   logic                   pkt_full_q, pkt_full_d;
   packet_t                pkt_data_q, pkt_data_d;
   logic [PTR_WIDTH-1:0]   disp_ptr_q, disp_ptr_d;
   logic                   res_full_q, res_full_d;
   worker_result_t         res_data_q, res_data_d;
   logic [PTR_WIDTH-1:0]   coll_ptr_q, coll_ptr_d;

   logic [NUM_WORKERS-1:0] d_grant, c_grant;
   logic [PTR_WIDTH-1:0]   d_idx, c_idx;
   logic                   d_any, c_any;
   logic                   dispatch_fire, pc_ready, accept;
   logic                   can_take, collect, drain;

   // Dispatch: requests are the worker READYs, so VALID follows READY combinationally
   rr_arbiter #(.N(NUM_WORKERS), .W(PTR_WIDTH)) u_disp_arb (
      .req(io.SEND_W_READY), .ptr(disp_ptr_q),
      .grant(d_grant), .grant_idx(d_idx), .any(d_any)
   );

   // Collect: requests are the worker result VALIDs
   rr_arbiter #(.N(NUM_WORKERS), .W(PTR_WIDTH)) u_coll_arb (
      .req(io.RECEIVE_WR_VALID), .ptr(coll_ptr_q),
      .grant(c_grant), .grant_idx(c_idx), .any(c_any)
   );

   // State registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         pkt_full_q <= 1'b0;
         pkt_data_q <= '0;
         disp_ptr_q <= '0;
         res_full_q <= 1'b0;
         res_data_q <= '0;
         coll_ptr_q <= '0;
      end else begin
         pkt_full_q <= pkt_full_d;
         pkt_data_q <= pkt_data_d;
         disp_ptr_q <= disp_ptr_d;
         res_full_q <= res_full_d;
         res_data_q <= res_data_d;
         coll_ptr_q <= coll_ptr_d;
      end
   end

   // Next state
   always_comb begin
      dispatch_fire = pkt_full_q && d_any;
      // Refill allowed in the same cycle the held packet leaves
      pc_ready      = !RST && (!pkt_full_q || dispatch_fire);
      accept        = io.RECEIVE_PC_VALID && pc_ready;
      can_take      = !res_full_q || io.SEND_WR_READY;
      collect       = !RST && can_take && c_any;
      drain         = res_full_q && io.SEND_WR_READY;

      pkt_full_d = pkt_full_q;
      pkt_data_d = pkt_data_q;
      disp_ptr_d = disp_ptr_q;
      if (dispatch_fire) begin
         pkt_full_d = 1'b0;
         disp_ptr_d = rr_next(d_idx);
      end
      if (accept) begin
         pkt_full_d = 1'b1;
         pkt_data_d = io.RECEIVE_PC_DATA;
      end

      res_full_d = res_full_q;
      res_data_d = res_data_q;
      coll_ptr_d = coll_ptr_q;
      if (drain) res_full_d = 1'b0;
      if (collect) begin
         res_full_d = 1'b1;
         res_data_d = io.RECEIVE_WR_DATA[c_idx];
         coll_ptr_d = rr_next(c_idx);
      end
   end

   // Outputs; everything forced low while RST is high
   always_comb begin
      io.RECEIVE_PC_READY = pc_ready;
      io.SEND_W_VALID     = (!RST && pkt_full_q) ? d_grant : '0;
      io.SEND_W_DATA      = RST ? '0 : pkt_data_q;
      io.RECEIVE_WR_READY = (!RST && can_take) ? c_grant : '0;
      io.SEND_WR_VALID    = !RST && res_full_q;
      io.SEND_WR_DATA     = RST ? '0 : res_data_q;
      io.BUSY             = !RST && (pkt_full_q || res_full_q);
   end

endmodule

// File: doc/worker_dispatcher.md
Name: worker_dispatcher

Overview:
- Sits between the packet source (matching/fetch stage) and a pool of NUM_WORKERS identical worker instances.
- Accepts one packet stream and dispatches each packet to exactly one ready worker, with round-robin fairness.
- Merges the workers' result streams into a single result stream for the writeback side, with round-robin arbitration.
- Provides one registered buffer on each side, so full throughput is one packet per cycle in and one result per cycle out.

Parameters:
- PACKET_WIDTH, shared param include value, width of one packet.
- WORKER_RESULT_WIDTH, 67 ({dest_option[2:0], dest_addr[15:0], color[15:0], data[31:0]}), width of one worker result.
- NUM_WORKERS, 4, number of workers served (2..8).
- PTR_WIDTH, 2 (clog2 of NUM_WORKERS), width of the round-robin pointers.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- RECEIVE_PC_VALID  in  1  upstream packet valid
- RECEIVE_PC_READY  out  1  dispatcher can accept a packet
- RECEIVE_PC_DATA  in  PACKET_WIDTH  upstream packet
- SEND_W_VALID  out  NUM_WORKERS  per-worker packet valid, at most one bit set
- SEND_W_READY  in  NUM_WORKERS  per-worker ready (worker RECEIVE_PC_READY)
- SEND_W_DATA  out  PACKET_WIDTH  held packet, broadcast to all workers
- RECEIVE_WR_VALID  in  NUM_WORKERS  per-worker result valid
- RECEIVE_WR_READY  out  NUM_WORKERS  per-worker result ready, at most one bit set
- RECEIVE_WR_DATA  in  NUM_WORKERS*WORKER_RESULT_WIDTH  worker results, worker i at bits [i*W +: W]
- SEND_WR_VALID  out  1  merged result valid
- SEND_WR_READY  in  1  downstream ready
- SEND_WR_DATA  out  WORKER_RESULT_WIDTH  merged result
- BUSY  out  1  packet or result buffer occupied

Behaviour:
Reset:
- Active on any cycle where RST=1 at the CLK edge.
- Clears pkt_full, res_full, disp_ptr=0 and coll_ptr=0.
- While RST=1: RECEIVE_PC_READY=0, SEND_W_VALID=0, RECEIVE_WR_READY=0, SEND_WR_VALID=0, BUSY=0. Data outputs are don't-care, but are cleared to 0.
- Reset mid-operation discards any held packet or result silently.

Dispatch side (states EMPTY/FULL, encoded by pkt_full):
- RECEIVE_PC_READY = !RST && (!pkt_full || dispatch_fire). Same-cycle refill is allowed.
- Accept when RECEIVE_PC_VALID && RECEIVE_PC_READY: latch the packet and set pkt_full at the next edge. Latency to SEND_W_VALID is 1 cycle.
- In FULL: grant = first i in the order disp_ptr, disp_ptr+1, ... (mod NUM_WORKERS) with SEND_W_READY[i]=1. SEND_W_VALID is one-hot on grant. If no worker is ready, SEND_W_VALID=0 and the packet is held.
- dispatch_fire = pkt_full && |SEND_W_READY. On fire, disp_ptr <= grant+1 mod NUM_WORKERS, and pkt_full clears unless a new packet is accepted in the same cycle.
- Worker READY must not depend on its VALID; SEND_W_VALID depends combinationally on SEND_W_READY.
- SEND_W_DATA is stable while pkt_full and no fire occurs.

Collect side (states EMPTY/FULL, encoded by res_full):
- can_take = !res_full || SEND_WR_READY.
- When can_take: grant = first i from coll_ptr (round robin) with RECEIVE_WR_VALID[i]=1. RECEIVE_WR_READY is one-hot on that grant. With no requests, it is 0.
- RECEIVE_WR_READY depends only on VALID and internal state, never combinationally on SEND_WR_READY beyond can_take.
- On collect: latch the granted RECEIVE_WR_DATA slice, set res_full, and coll_ptr <= grant+1.
- SEND_WR_VALID = res_full. Data is stable until SEND_WR_READY is sampled high.
- Drain and refill in the same cycle are allowed.
- Multiple results from one worker leave in that worker's issue order. There is no reordering across a single worker.

Misc:
- BUSY = pkt_full || res_full.
- Results are not attributed to packets; the dispatcher keeps no in-flight count.

Decomposition:
- Shared param include holds:
  - PACKET_WIDTH, WORKER_RESULT_WIDTH, NUM_WORKERS.
  - Field offsets for the result format.
  - The make_worker_result constructor, reused by the bench.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: grant one-hot[N], grant_idx, any.
  - Purely combinational; instantiated twice, once for dispatch and once for collect.
  - The pointer registers stay in worker_dispatcher.

Test Plan:
1. RST=1 for 1 cycle with RECEIVE_PC_VALID=1 -> RECEIVE_PC_READY=0, SEND_W_VALID=4'b0000, RECEIVE_WR_READY=0, SEND_WR_VALID=0, BUSY=0.
2. All workers ready, 5 back-to-back packets with data1=1..5 -> go to workers 0,1,2,3,0 on consecutive cycles; first SEND_W_VALID one cycle after first accept; RECEIVE_PC_READY held at 1.
3. disp_ptr=1, SEND_W_READY=4'b1101 -> packet goes to worker 2 (SEND_W_VALID=4'b0100), next packet goes to worker 3; with SEND_W_READY=0 for 4 cycles, packet held and RECEIVE_PC_READY=0.
4. Workers 0 and 2 present continuous results (color 16'h0000 / 16'h0002, data 32'hdead_beef), SEND_WR_READY=1 -> SEND_WR_DATA colors alternate 0000,0002,0000,0002; one result per cycle.
5. Result buffered and SEND_WR_READY=0 for 5 cycles -> SEND_WR_DATA unchanged, RECEIVE_WR_READY=0; release -> every worker result appears exactly once, in per-worker order (e.g. distribute's two results in issue order).
6. Packet held with all workers not ready and a result buffered, then RST=1 -> next cycle BUSY=0, SEND_W_VALID=0, SEND_WR_VALID=0; after release, first new packet goes to worker 0.
